// File: rtl/aes_pkg.sv
// Shared AES definitions: FIPS-197 S-box tables, state byte layout, and the
// SubBytes stage state encoding.
package aes_pkg;

  localparam int STATE_W   = 128;
  localparam int BYTE_W    = 8;
  localparam int NUM_WORDS = 4;
  localparam int NUM_ROWS  = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stage_e;

  // MSB of the byte at (word, row); word0 occupies [127:96], row0 is its top byte.
  function automatic int byte_msb(input int word, input int row);
    return STATE_W - 1 - BYTE_W * (NUM_ROWS * word + row);
  endfunction

  localparam logic [7:0] FWD_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES byte substitution; inv selects the inverse S-box.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  input  logic       inv,
  output logic [7:0] out_byte
);

  assign out_byte = inv ? INV_SBOX[in_byte] : FWD_SBOX[in_byte];

endmodule

// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes stage: substitutes COLS_PER_CYCLE columns per clock
// through shared S-boxes and holds the finished state under valid/ready.
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int         NCOL     = NUM_WORDS / COLS_PER_CYCLE;
  localparam int         LANES    = NUM_ROWS * COLS_PER_CYCLE;
  localparam logic [1:0] LAST_CNT = 2'(NCOL - 1);

  stage_e         state_q;
  stage_e         state_d;
  logic [1:0]     cnt_q;
  logic           inv_q;
  logic [127:0]   work_q;
  logic [127:0]   out_data_q;
  logic           accept;
  int             lane_msb [LANES];
  logic [7:0]     lane_in  [LANES];
  logic [7:0]     lane_out [LANES];

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lanes cover consecutive bytes: columns cnt*COLS_PER_CYCLE onward, row-major within a column.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_msb[j] = byte_msb(int'(cnt_q) * COLS_PER_CYCLE + j / NUM_ROWS, j % NUM_ROWS);
      lane_in[j]  = work_q[lane_msb[j] -: BYTE_W];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .in_byte  (lane_in[g]),
      .inv      (inv_q),
      .out_byte (lane_out[g])
    );
  end

  // NOTE: the work register is a pure data holder gated by accept, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rst_n && accept) work_q <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      inv_q      <= 1'b0;
      out_data_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      inv_q <= in_inv;
    end else if (state_q == BUSY) begin
      cnt_q <= (cnt_q == LAST_CNT) ? 2'd0 : cnt_q + 2'd1;
      for (int j = 0; j < LANES; j++) begin
        out_data_q[lane_msb[j] -: BYTE_W] <= lane_out[j];
      end
    end
  end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Self-checking bench: three stage instances (1, 2, 4 columns per cycle) against
// an S-box model derived from GF(2^8) inversion plus the affine transform.
module tb_sub_bytes_seq;

  localparam int NDUT = 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid  [NDUT];
  logic         in_ready  [NDUT];
  logic [127:0] in_data   [NDUT];
  logic         in_inv    [NDUT];
  logic         out_valid [NDUT];
  logic         out_ready [NDUT];
  logic [127:0] out_data  [NDUT];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fwd_ref [256];
  logic [7:0] inv_ref [256];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sub_bytes_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_inv    (in_inv[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] data;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  task automatic build_model();
    logic [7:0] x_inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      x_inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) x_inv = 8'(y);
      s = x_inv ^ rotl8(x_inv, 1) ^ rotl8(x_inv, 2) ^ rotl8(x_inv, 3) ^ rotl8(x_inv, 4) ^ 8'h63;
      fwd_ref[x] = s;
      inv_ref[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++)
      r[8*k +: 8] = inv ? inv_ref[d[8*k +: 8]] : fwd_ref[d[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Waits for in_ready, hands over one block, scrambles the inputs mid-block,
  // then checks latency and result. Entered and left at posedge+1.
  task automatic run_block(input int d, input logic [127:0] data, input logic inv,
                           input logic [127:0] exp, input string name);
    int waited = 0;
    int lat = 0;
    while (!in_ready[d] && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    check($sformatf("%s/ready d%0d", name, d), 128'(in_ready[d]), 128'(1));
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    in_inv[d]   = inv;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_inv[d]   = ~inv;
    in_data[d]  = rand128();
    while (!out_valid[d] && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check($sformatf("%s/latency d%0d", name, d), 128'(lat), 128'(4 >> d));
    check($sformatf("%s/data d%0d", name, d), out_data[d], exp);
    @(posedge clk); #1;
  endtask

  vec_t vecs [6];

  initial begin
    logic [127:0] a_data, a_exp, b_data, b_exp, d;
    logic         inv;
    int           lat;

    vecs[0] = '{"fips_b_round1", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230};
    vecs[1] = '{"fips_inverse",  128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
    vecs[2] = '{"inv_all_63",    {16{8'h63}}, 1'b1, {16{8'h00}}};
    vecs[3] = '{"fwd_all_00",    {16{8'h00}}, 1'b0, {16{8'h63}}};
    vecs[4] = '{"fwd_all_ff",    {16{8'hff}}, 1'b0, {16{8'h16}}};
    vecs[5] = '{"fwd_all_53",    {16{8'h53}}, 1'b0, {16{8'hed}}};

    build_model();

    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      in_inv[i]    = 1'b0;
      out_ready[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("reset/out_valid d%0d", i), 128'(out_valid[i]), 128'(0));
      check($sformatf("reset/out_data d%0d", i), out_data[i], 128'(0));
      check($sformatf("reset/in_ready d%0d", i), 128'(in_ready[i]), 128'(1));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int d_i = 0; d_i < NDUT; d_i++)
      for (int v = 0; v < 6; v++)
        run_block(d_i, vecs[v].data, vecs[v].inv, vecs[v].exp, vecs[v].name);

    // Randomised mixed forward/inverse blocks against the model.
    for (int d_i = 0; d_i < NDUT; d_i++)
      for (int n = 0; n < 12; n++) begin
        d   = rand128();
        inv = 1'($urandom_range(0, 1));
        run_block(d_i, d, inv, ref_sub(d, inv), "random");
      end

    // Backpressure in DONE with a second block waiting, then back-to-back handoff.
    a_data = rand128();
    a_exp  = ref_sub(a_data, 1'b0);
    b_data = rand128();
    b_exp  = ref_sub(b_data, 1'b1);
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = a_data;
    in_inv[0]    = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("stall/latency", 128'(lat), 128'(4));
    in_valid[0] = 1'b1;
    in_data[0]  = b_data;
    in_inv[0]   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("stall/out_data", out_data[0], a_exp);
      check("stall/out_valid", 128'(out_valid[0]), 128'(1));
      check("stall/in_ready", 128'(in_ready[0]), 128'(0));
    end
    out_ready[0] = 1'b1;
    #1;
    check("b2b/in_ready", 128'(in_ready[0]), 128'(1));
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    in_inv[0]   = 1'b0;
    check("b2b/out_valid_drop", 128'(out_valid[0]), 128'(0));
    check("b2b/busy_not_ready", 128'(in_ready[0]), 128'(0));
    lat = 0;
    while (!out_valid[0] && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("b2b/latency", 128'(lat), 128'(4));
    check("b2b/data", out_data[0], b_exp);
    @(posedge clk); #1;

    // Reset while the block is two columns in.
    in_valid[0] = 1'b1;
    in_data[0]  = rand128();
    in_inv[0]   = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset/out_valid", 128'(out_valid[0]), 128'(0));
    check("midreset/out_data", out_data[0], 128'(0));
    check("midreset/in_ready", 128'(in_ready[0]), 128'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midreset/idle_hold", 128'(out_valid[0]), 128'(0));
    run_block(0, vecs[0].data, 1'b0, vecs[0].exp, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
